// File: rtl/stream_parity.sv
// Single-stage parity generate/check register slice with a valid/ready handshake on both sides.
// Define STREAM_PARITY_ERR_CNT_EN to build the saturating mismatch counter; otherwise err_cnt is 0.
module stream_parity #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ODD    = 0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_par,
    input  logic              s_chk,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_par,
    output logic              m_err,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam logic OddBit = (ODD != 0);

    typedef enum logic {
        StEmpty,
        StFull
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              err_q, err_d;

    logic par_calc;
    logic mismatch;
    logic accept;

    always_comb begin
        par_calc = (^s_data) ^ OddBit;
        mismatch = s_chk & (par_calc != s_par);
        // Ready only looks at the output side so upstream never sees a valid->ready loop.
        s_ready  = (state_q == StEmpty) | m_ready;
        accept   = s_valid & s_ready;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        err_d   = err_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StFull;
                end
            end
            StFull: begin
                if (accept) begin
                    state_d = StFull;
                end else if (m_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase

        if (accept) begin
            data_d = s_data;
            par_d  = par_calc;
            err_d  = mismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            par_q   <= par_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        m_valid = (state_q == StFull);
        m_data  = data_q;
        m_par   = par_q;
        m_err   = err_q;
    end

`ifdef STREAM_PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle increment; the count stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (accept && mismatch && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_stream_parity.sv
// Directed self-checking bench for stream_parity: reset, generate/check modes, backpressure,
// streaming throughput and the error counter (expected counts depend on STREAM_PARITY_ERR_CNT_EN).
module tb_stream_parity;

`ifdef STREAM_PARITY_ERR_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_par;
    logic       s_chk;
    logic       s_valid;
    logic       m_ready;
    logic       cnt_clr;

    logic       s_ready;
    logic [7:0] m_data;
    logic       m_par;
    logic       m_err;
    logic       m_valid;
    logic [1:0] err_cnt;

    logic       s_ready_odd;
    logic [7:0] m_data_odd;
    logic       m_par_odd;
    logic       m_err_odd;
    logic       m_valid_odd;
    logic [1:0] err_cnt_odd;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    stream_parity #(
        .DATA_W (8),
        .ODD    (0),
        .CNT_W  (2)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_par   (s_par),
        .s_chk   (s_chk),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_par   (m_par),
        .m_err   (m_err),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .cnt_clr (cnt_clr),
        .err_cnt (err_cnt)
    );

    stream_parity #(
        .DATA_W (8),
        .ODD    (1),
        .CNT_W  (2)
    ) u_dut_odd (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_par   (s_par),
        .s_chk   (s_chk),
        .s_valid (s_valid),
        .s_ready (s_ready_odd),
        .m_data  (m_data_odd),
        .m_par   (m_par_odd),
        .m_err   (m_err_odd),
        .m_valid (m_valid_odd),
        .m_ready (m_ready),
        .cnt_clr (cnt_clr),
        .err_cnt (err_cnt_odd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 3) ? 3 : v + 1;
    endfunction

    initial begin
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA5;
        s_par   = 1'b0;
        s_chk   = 1'b1;
        m_ready = 1'b1;
        cnt_clr = 1'b0;

        // Reset held two cycles with a valid input beat present.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_s_ready", 64'(s_ready), 64'd1);
            check("rst_err_cnt", 64'(err_cnt), 64'd0);
            check("rst_m_data", 64'(m_data), 64'd0);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        check("post_rst_s_ready", 64'(s_ready), 64'd1);
        step();
        check("post_rst_no_beat", 64'(m_valid), 64'd0);

        // Generate mode.
        s_data  = 8'hA5;
        s_chk   = 1'b0;
        s_par   = 1'b1;
        s_valid = 1'b1;
        step();
        check("gen_a5_valid", 64'(m_valid), 64'd1);
        check("gen_a5_data", 64'(m_data), 64'hA5);
        check("gen_a5_par", 64'(m_par), 64'd0);
        check("gen_a5_err", 64'(m_err), 64'd0);
        check("gen_a5_par_odd", 64'(m_par_odd), 64'd1);
        check("gen_a5_err_odd", 64'(m_err_odd), 64'd0);

        s_data = 8'h07;
        s_par  = 1'b0;
        step();
        check("gen_07_par", 64'(m_par), 64'd1);
        check("gen_07_err", 64'(m_err), 64'd0);
        check("gen_07_par_odd", 64'(m_par_odd), 64'd0);
        check("gen_07_cnt", 64'(err_cnt), 64'd0);

        // Check mode: mismatch then match.
        s_chk = 1'b1;
        s_par = 1'b0;
        step();
        exp_cnt = 1;
        check("chk_bad_err", 64'(m_err), 64'd1);
        check("chk_bad_cnt", 64'(err_cnt), CntEn ? 64'(exp_cnt) : 64'd0);

        s_par = 1'b1;
        step();
        check("chk_good_err", 64'(m_err), 64'd0);
        check("chk_good_cnt", 64'(err_cnt), CntEn ? 64'(exp_cnt) : 64'd0);

        // Backpressure: one beat held while a new one waits upstream.
        s_chk  = 1'b0;
        s_data = 8'h3C;
        step();
        check("bp_first_data", 64'(m_data), 64'h3C);
        m_ready = 1'b0;
        s_data  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_s_ready", 64'(s_ready), 64'd0);
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_m_data", 64'(m_data), 64'h3C);
            check("bp_m_par", 64'(m_par), 64'd0);
        end

        // Full-rate streaming, one beat per cycle.
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d      = 8'h10 + 8'(i);
            s_data = d;
            step();
            check("stream_valid", 64'(m_valid), 64'd1);
            check("stream_data", 64'(m_data), 64'(d));
            check("stream_par", 64'(m_par), 64'(^d));
        end
        s_valid = 1'b0;
        step();
        check("drain_valid", 64'(m_valid), 64'd0);

        // Counter saturation at 3 with CNT_W=2.
        s_data  = 8'h07;
        s_par   = 1'b0;
        s_chk   = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_cnt = sat_inc(exp_cnt);
            check("sat_cnt", 64'(err_cnt), CntEn ? 64'(exp_cnt) : 64'd0);
            check("sat_err", 64'(m_err), 64'd1);
        end
        cnt_clr = 1'b1;
        step();
        exp_cnt = 0;
        check("clr_prio_cnt", 64'(err_cnt), 64'd0);
        check("clr_prio_err", 64'(m_err), 64'd1);
        cnt_clr = 1'b0;
        step();
        exp_cnt = 1;
        check("after_clr_cnt", 64'(err_cnt), CntEn ? 64'(exp_cnt) : 64'd0);
        s_valid = 1'b0;
        cnt_clr = 1'b1;
        step();
        check("clr_idle_cnt", 64'(err_cnt), 64'd0);
        cnt_clr = 1'b0;

        // Reset drops a held output beat.
        s_valid = 1'b1;
        step();
        check("pre_rst_err", 64'(m_err), 64'd1);
        check("pre_rst_cnt", 64'(err_cnt), CntEn ? 64'd1 : 64'd0);
        m_ready = 1'b0;
        s_valid = 1'b1;
        rst     = 1'b1;
        step();
        check("drop_m_valid", 64'(m_valid), 64'd0);
        check("drop_m_data", 64'(m_data), 64'd0);
        check("drop_m_par", 64'(m_par), 64'd0);
        check("drop_m_err", 64'(m_err), 64'd0);
        check("drop_cnt", 64'(err_cnt), 64'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        check("drop_s_ready", 64'(s_ready), 64'd1);
        step();
        check("drop_no_beat", 64'(m_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stream_parity.md
STREAM_PARITY -- requirements
Module: stream_parity

Interface
REQ-001 SHALL provide parameter: DATA_W, 8, payload width in bits (legal range 1..64).
REQ-002 SHALL provide parameter: ODD, 0, parity sense (0 = even: data plus parity has an even count of ones; 1 = odd).
REQ-003 SHALL provide parameter: CNT_W, 16, error counter width (legal range 1..32).
REQ-004 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- s_data  input  DATA_W  input payload.
- s_par  input  1  received parity bit; used only in check mode.
- s_chk  input  1  per-beat mode: 0 = generate, 1 = check.
- s_valid  input  1  input beat valid.
- s_ready  output  1  block can accept an input beat.
- m_data  output  DATA_W  registered payload.
- m_par  output  1  computed parity of m_data.
- m_err  output  1  parity mismatch flag; meaningful in check mode only.
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the output beat.
- cnt_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  saturating count of mismatched beats.

Function
REQ-005 SHALL compute parity as the XOR reduction of all DATA_W bits of s_data, inverted when ODD=1.
REQ-006 SHALL accept an input beat on a rising edge where s_valid=1 and s_ready=1 (the beat is "accepted").
REQ-007 SHALL drive s_ready = (m_valid==0) | (m_ready==1), combinationally, with no dependency on s_valid.
REQ-008 On acceptance, SHALL register the beat:
- m_data <= s_data.
- m_par <= computed parity.
- m_err <= s_chk & (computed parity != s_par).
- m_valid <= 1.
- Latency is exactly 1 cycle.
REQ-009 SHALL clear m_valid on an edge where m_valid=1, m_ready=1 and no beat is accepted.
REQ-010 While m_valid=1 and m_ready=0, m_data, m_par and m_err SHALL hold stable.
REQ-011 SHALL sustain one beat per cycle when s_valid=1 and m_ready=1 continuously; no bubbles.
REQ-012 In generate mode (s_chk=0), s_par SHALL be ignored and m_err SHALL be 0.
REQ-013 The sole state machine SHALL have two states, derived from m_valid:
- EMPTY to FULL on acceptance.
- FULL to FULL on acceptance while draining.
- FULL to EMPTY on drain with no acceptance.
- EMPTY holds otherwise.

Reset
REQ-014 When rst=1 at a rising edge, the block SHALL force m_valid=0, m_data=0, m_par=0, m_err=0 and err_cnt=0.
REQ-015 An input beat presented during reset SHALL be discarded.
REQ-016 An output beat held when reset occurs SHALL be dropped without a handshake.
REQ-017 s_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-018 Macro STREAM_PARITY_ERR_CNT_EN SHALL control the error counter.
REQ-019 With STREAM_PARITY_ERR_CNT_EN defined, err_cnt SHALL behave as follows:
- Increments by 1 on each accepted beat with s_chk=1 and a parity mismatch.
- Saturates at 2^CNT_W-1.
- Is cleared to 0 by cnt_clr=1.
- cnt_clr has priority over a same-cycle increment, giving a result of 0.
- The new value is visible in the same cycle as the corresponding m_valid.
REQ-020 Without STREAM_PARITY_ERR_CNT_EN, err_cnt SHALL be tied to constant 0, cnt_clr SHALL be ignored, and no counter flops SHALL be synthesised.

Verification
REQ-021 Reset: assert rst for 2 cycles with s_valid=1 -> m_valid=0, s_ready=1, err_cnt=0, and no output beat appears.
REQ-022 Generate mode: DATA_W=8, ODD=0, s_chk=0.
- s_data=8'hA5 -> one cycle later m_par=0, m_err=0.
- s_data=8'h07 -> m_par=1.
- Repeat with ODD=1: 8'hA5 -> m_par=1.
REQ-023 Check mode: s_data=8'h07, s_par=0, s_chk=1 -> m_err=1, err_cnt=1 (macro defined).
REQ-024 Check mode: s_data=8'h07, s_par=1, s_chk=1 -> m_err=0, err_cnt unchanged.
REQ-025 Backpressure: hold m_ready=0 after one beat -> s_ready=0 and outputs stable for 5 cycles. Then m_ready=1 and s_valid=1 every cycle for 10 beats -> 10 output beats in 10 cycles, in order, with no loss or duplication.
REQ-026 Counter: CNT_W=2, 5 mismatched beats -> err_cnt saturates at 3. Then cnt_clr=1 coincident with a mismatched beat -> err_cnt=0. Without the macro, err_cnt=0 throughout.
